// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch stage: default address and
// instruction widths, and the packed {pc, instruction} entry that the
// prefetch FIFO carries toward decode.
package fetch_pkg;

  localparam int FETCH_D = 10;  // default instruction address width
  localparam int FETCH_W = 9;   // default instruction word width

  typedef struct packed {
    logic [FETCH_D-1:0] pc;
    logic [FETCH_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// inst_fifo
// Small synchronous FIFO for queued fetch entries.  Reads come straight
// from the head slot so the entry is usable in the cycle it becomes valid.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-low; empties the FIFO
//   flush      - synchronous clear of pointers and count
//   push       - write push_data at the tail (caller guarantees space,
//                or a simultaneous pop)
//   push_data  - entry to write
//   pop        - advance the head (caller guarantees count != 0)
//   head_data  - entry at the head pointer
//   count      - number of stored entries, 0..DEPTH
module inst_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    head_reg;
  logic [AW-1:0]    tail_reg;
  logic [AW:0]      count_reg;

  // Storage is not reset: contents beyond count are don't-care.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[tail_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + 1'b1;
      end
      if (pop) begin
        head_reg <= head_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem_reg[head_reg];
  assign count     = count_reg;

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer
// Instruction fetch stage between the PC and decode.  Every cycle it may
// issue the PC to the synchronous instruction memory; the returned word is
// paired with its address and queued for decode.  Credits (queued entries
// plus the one fetch in flight) decide whether a new address may be
// issued; when they run out the PC is held.  A taken jump flushes both the
// queue and the in-flight fetch.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-low
//   pcValue    - current program counter
//   jumpEn     - taken jump this cycle; flushes all pending work
//   pcHold     - PC must keep its value next cycle
//   imemAddr   - instruction memory address (= pcValue)
//   imemData   - memory read data, one cycle after its address
//   instValid  - head instruction valid toward decode
//   instReady  - decode accepts the head
//   instData   - head instruction word (0 when not valid)
//   instPc     - head instruction address (0 when not valid)
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int D     = FETCH_D,
  parameter int W     = FETCH_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [D-1:0] pcValue,
  input  logic         jumpEn,
  output logic         pcHold,
  output logic [D-1:0] imemAddr,
  input  logic [W-1:0] imemData,
  output logic         instValid,
  input  logic         instReady,
  output logic [W-1:0] instData,
  output logic [D-1:0] instPc
);

  localparam int AW = $clog2(DEPTH);

  logic           inflight_reg;
  logic [D-1:0]   inflight_pc_reg;
  logic [AW:0]    count;
  logic [AW+1:0]  credit;
  logic           issue;
  logic           push;
  logic           pop;
  logic           head_valid;
  logic [D+W-1:0] head_entry;

  // Credit deliberately ignores a same-cycle pop; this keeps instReady off
  // the pcHold path and guarantees the single late landing always fits.
  assign credit = {1'b0, count} + {{(AW+1){1'b0}}, inflight_reg};
  assign issue  = reset && !jumpEn && (credit < (AW+2)'(DEPTH));
  assign pcHold = reset && !jumpEn && !issue;

  assign imemAddr = pcValue;

  assign push       = reset && !jumpEn && inflight_reg;
  assign head_valid = reset && !jumpEn && (count != '0);
  assign pop        = head_valid && instReady;

  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      // A jump clears issue, so the in-flight fetch is dropped here too.
      inflight_reg <= issue;
      if (issue) begin
        inflight_pc_reg <= pcValue;
      end
    end
  end

  inst_fifo #(
    .WIDTH (D + W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (jumpEn),
    .push      (push),
    .push_data ({inflight_pc_reg, imemData}),
    .pop       (pop),
    .head_data (head_entry),
    .count     (count)
  );

  assign instValid = head_valid;
  assign instPc    = head_valid ? head_entry[D+W-1:W] : '0;
  assign instData  = head_valid ? head_entry[W-1:0]   : '0;

endmodule
